// File: rtl/uart_aes_packer_pkg.sv
// rtl/uart_aes_packer_pkg.sv - shared widths and FSM state type for the UART-to-AES packer
// Purpose: default byte/block widths, bytes per AES field, packer FSM states.
// Ports: none (package).
package uart_aes_packer_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_N          = 128;
    localparam int BLOCK_BYTES    = DEF_N / DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        KEY,
        TEXT,
        HOLD
    } packer_state_e;

endpackage

// File: rtl/uart_aes_packer_if.sv
// rtl/uart_aes_packer_if.sv - byte input and AES block output bundle of the packer
// Purpose: groups the UART byte handshake and the AES frame handshake.
// Ports: in_data/in_valid/in_ready (byte stream), key_out/pt_out/blk_valid/blk_ready
//        (assembled frame), frame_err (discard pulse).
//        slave = packer side, master = UART/AES environment side.
interface uart_aes_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 128
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0]          key_out;
    logic [N-1:0]          pt_out;
    logic                  blk_valid;
    logic                  blk_ready;
    logic                  frame_err;

    modport slave (
        input  in_data, in_valid, blk_ready,
        output in_ready, key_out, pt_out, blk_valid, frame_err
    );

    modport master (
        output in_data, in_valid, blk_ready,
        input  in_ready, key_out, pt_out, blk_valid, frame_err
    );
endinterface

// File: rtl/uart_aes_packer_byte_shift_reg.sv
// rtl/uart_aes_packer_byte_shift_reg.sv - N-bit register loaded one byte at a time from the LSB end
// Purpose: first byte shifted in ends up in q[N-1:N-DATA_WIDTH] after N/DATA_WIDTH shifts.
// Ports: clk, rst (sync, active-high, clears q), shift_en, din (byte), q (register).
module byte_shift_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [N-1:0]          q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[N-DATA_WIDTH-1:0], din};
        end
    end
endmodule

// File: rtl/uart_aes_packer.sv
// rtl/uart_aes_packer.sv - packs a 32-byte UART frame into an AES key and plaintext block
// Purpose: first 16 bytes form key_out, next 16 form pt_out; the frame is then held
//          until the AES core takes it. A gap of TIMEOUT idle cycles inside a frame
//          discards the partial frame and pulses frame_err.
// Ports: clk, rst (sync, active-high), bus (uart_aes_packer_if.slave).
module uart_aes_packer
    import uart_aes_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N          = DEF_N,
    parameter int TIMEOUT    = 4096
) (
    input  logic                clk,
    input  logic                rst,
    uart_aes_packer_if.slave    bus
);
    localparam int BYTES = N / DATA_WIDTH;
    localparam int CNT_W = $clog2(BYTES);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    packer_state_e    state;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tmo;
    logic             in_ready_q;
    logic             blk_valid_q;
    logic             frame_err_q;
    logic             accept;

    // in_ready is registered, so accept never depends combinationally on in_valid
    // feeding back into in_ready.
    assign accept        = bus.in_valid && in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.frame_err = frame_err_q;

    byte_shift_reg #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_key_sr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept && (state == IDLE || state == KEY)),
        .din      (bus.in_data),
        .q        (bus.key_out)
    );

    byte_shift_reg #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_pt_sr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept && state == TEXT),
        .din      (bus.in_data),
        .q        (bus.pt_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            tmo         <= '0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    tmo        <= '0;
                    if (accept) begin
                        cnt   <= CNT_W'(1);
                        state <= KEY;
                    end
                end
                KEY, TEXT: begin
                    // An accepted byte takes priority over an expiring timeout.
                    if (accept) begin
                        tmo <= '0;
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (state == KEY) begin
                                state <= TEXT;
                            end else begin
                                state       <= HOLD;
                                in_ready_q  <= 1'b0;
                                blk_valid_q <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (tmo == TMO_LAST) begin
                        // Partial frame dropped; key/pt contents are left as-is.
                        frame_err_q <= 1'b1;
                        cnt         <= '0;
                        tmo         <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.blk_ready) begin
                        state       <= IDLE;
                        blk_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_aes_packer.sv
// tb/tb_uart_aes_packer.sv - self-checking bench for uart_aes_packer
module tb_uart_aes_packer;
    import uart_aes_packer_pkg::*;

    localparam int DW  = 8;
    localparam int NW  = 128;
    localparam int TMO = 16;
    localparam int FRAME_BYTES = 2 * BLOCK_BYTES;

    typedef struct packed {
        logic [NW-1:0] key;
        logic [NW-1:0] pt;
    } frame_t;

    logic   clk = 1'b0;
    logic   rst;
    int     n_checks = 0;
    int     n_errors = 0;
    int     err_pulses = 0;
    int     xfers = 0;
    frame_t sb[$];

    always #5 clk = ~clk;

    uart_aes_packer_if #(.DATA_WIDTH(DW), .N(NW)) bus ();

    uart_aes_packer #(.DATA_WIDTH(DW), .N(NW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) err_pulses++;
        if (bus.blk_valid === 1'b1 && bus.blk_ready === 1'b1) xfers++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        int g = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) check("in_ready wait", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] frame_byte(input logic [NW-1:0] key, input logic [NW-1:0] pt, input int i);
        if (i < BLOCK_BYTES) return key[NW-1-DW*i -: DW];
        return pt[NW-1-DW*(i-BLOCK_BYTES) -: DW];
    endfunction

    // race_idx >= 0 inserts a TMO-1 idle gap just before that byte.
    task automatic send_frame(input logic [NW-1:0] key, input logic [NW-1:0] pt,
                              input int max_gap, input int race_idx);
        frame_t f;
        f.key = key;
        f.pt  = pt;
        sb.push_back(f);
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (i == race_idx) idle(TMO - 1);
            else if (i > 0 && max_gap > 0) idle($urandom_range(max_gap, 0));
            send_byte(frame_byte(key, pt, i));
        end
    endtask

    task automatic expect_block(input string tag);
        frame_t e;
        int g = 0;
        while (bus.blk_valid !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        check({tag, " blk_valid"}, bus.blk_valid, 1);
        check({tag, " sb depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " key_out"}, bus.key_out, e.key);
            check({tag, " pt_out"}, bus.pt_out, e.pt);
        end
    endtask

    function automatic logic [NW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [NW-1:0] fk, fp, k, p;
        int e0, x0;
        fk = 128'h000102030405060708090a0b0c0d0e0f;
        fp = 128'h00112233445566778899aabbccddeeff;

        rst = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.blk_ready = 1'b0;
        repeat (3) tick();
        check("rst in_ready", bus.in_ready, 0);
        check("rst blk_valid", bus.blk_valid, 0);
        check("rst frame_err", bus.frame_err, 0);
        check("rst key_out", bus.key_out, 0);
        check("rst pt_out", bus.pt_out, 0);
        rst = 1'b0;
        tick();
        check("post rst in_ready", bus.in_ready, 1);

        // FIPS-197 frame, held under backpressure
        send_frame(fk, fp, 0, -1);
        check("fips blk_valid latency", bus.blk_valid, 1);
        expect_block("fips");
        check("fips hold in_ready", bus.in_ready, 0);
        bus.in_data  = 8'hAA;
        bus.in_valid = 1'b1;
        x0 = xfers;
        repeat (50) begin
            tick();
            check("bp in_ready", bus.in_ready, 0);
            check("bp blk_valid", bus.blk_valid, 1);
            check("bp key_out", bus.key_out, fk);
            check("bp pt_out", bus.pt_out, fp);
        end
        bus.in_valid  = 1'b0;
        bus.blk_ready = 1'b1;
        tick();
        check("release blk_valid", bus.blk_valid, 0);
        check("release in_ready", bus.in_ready, 1);
        repeat (5) tick();
        check("release xfer count", xfers - x0, 1);

        // Timeout after 5 key bytes
        e0 = err_pulses;
        k = rand128();
        for (int i = 0; i < 5; i++) send_byte(k[NW-1-DW*i -: DW]);
        for (int i = 1; i < TMO; i++) begin
            tick();
            check("tmo early frame_err", bus.frame_err, 0);
        end
        tick();
        check("tmo frame_err pulse", bus.frame_err, 1);
        tick();
        check("tmo frame_err end", bus.frame_err, 0);
        check("tmo pulse count", err_pulses - e0, 1);
        k = rand128();
        p = rand128();
        send_frame(k, p, 0, -1);
        expect_block("after tmo");
        tick();
        check("after tmo blk_valid", bus.blk_valid, 0);
        check("after tmo pulse count", err_pulses - e0, 1);

        // Byte arriving on the final timeout cycle wins
        e0 = err_pulses;
        send_frame(rand128(), rand128(), 0, 3);
        expect_block("race");
        tick();
        check("race no frame_err", err_pulses - e0, 0);

        // Reset in the middle of a frame
        e0 = err_pulses;
        k = rand128();
        p = rand128();
        for (int i = 0; i < 20; i++) send_byte(frame_byte(k, p, i));
        rst = 1'b1;
        tick();
        check("mid rst in_ready", bus.in_ready, 0);
        check("mid rst blk_valid", bus.blk_valid, 0);
        check("mid rst frame_err", bus.frame_err, 0);
        check("mid rst key_out", bus.key_out, 0);
        check("mid rst pt_out", bus.pt_out, 0);
        rst = 1'b0;
        tick();
        check("mid rst in_ready back", bus.in_ready, 1);
        send_frame(rand128(), rand128(), 0, -1);
        expect_block("after rst");
        tick();
        check("after rst no frame_err", err_pulses - e0, 0);

        // Random inter-byte gaps, always below the timeout
        e0 = err_pulses;
        for (int f = 0; f < 100; f++) begin
            send_frame(rand128(), rand128(), TMO - 2, -1);
            expect_block("rand");
            tick();
        end
        check("rand no frame_err", err_pulses - e0, 0);
        check("rand sb drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
